// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: priority FSM states, read-owner tags,
// the data width and a saturating increment for the optional statistics counters.
package dmem_arb_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        CORE_PRIO  = 1'b0,
        HOST_FORCE = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CORE = 2'b01,
        OWN_HOST = 2'b10
    } rd_owner_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc16 = value;
        end else begin
            sat_inc16 = value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating 4-bit starvation counter; exposes the value it will hold after the
// next edge so the arbiter can switch priority in the same cycle the limit is reached.
module starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic       clk,
    input  logic       start,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count,
    output logic [3:0] count_next
);

    localparam logic [3:0] LIMIT_C = 4'(LIMIT);

    logic [3:0] count_r;
    logic [3:0] count_next_s;

    // next count: clear wins over increment, increment stops at the limit
    always_comb begin
        count_next_s = count_r;
        if (start || clr) begin
            count_next_s = 4'd0;
        end else if (inc) begin
            if (count_r >= LIMIT_C) begin
                count_next_s = LIMIT_C;
            end else begin
                count_next_s = count_r + 4'd1;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (start) begin
            count_r <= 4'd0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the core load/store path and the host port.
// Optional grant/conflict statistics are enabled with the DMEM_ARB_STATS_EN macro.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  start,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_stall,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_rvalid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  host_rvalid,
    output logic                  mem_readmem,
    output logic                  mem_writemem,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]           stat_core_grants,
    output logic [15:0]           stat_host_grants,
    output logic [15:0]           stat_conflicts,
`endif
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    arb_state_e            state_r;
    arb_state_e            state_next_s;
    rd_owner_e             rd_owner_r;
    rd_owner_e             rd_owner_next_s;
    logic                  core_req_s;
    logic                  core_win_s;
    logic                  host_win_s;
    logic [3:0]            starve_cnt_s;
    logic [3:0]            starve_next_s;
    logic [DATA_WIDTH-1:0] core_hold_r;
    logic [DATA_WIDTH-1:0] host_hold_r;
    logic                  core_rvalid_s;
    logic                  host_rvalid_s;

    assign core_req_s = core_rd | core_wr;

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve_counter (
        .clk        (clk),
        .start      (start),
        .inc        (host_req & ~host_win_s),
        .clr        (host_win_s | ~host_req),
        .count      (starve_cnt_s),
        .count_next (starve_next_s)
    );

    // winner selection from current requests and priority state; nobody wins in reset
    always_comb begin
        core_win_s = 1'b0;
        host_win_s = 1'b0;
        if (start) begin
            core_win_s = 1'b0;
            host_win_s = 1'b0;
        end else begin
            case (state_r)
                CORE_PRIO: begin
                    if (core_req_s) begin
                        core_win_s = 1'b1;
                    end else begin
                        host_win_s = host_req;
                    end
                end
                HOST_FORCE: begin
                    if (host_req) begin
                        host_win_s = 1'b1;
                    end else begin
                        core_win_s = core_req_s;
                    end
                end
                default: begin
                    core_win_s = 1'b0;
                    host_win_s = 1'b0;
                end
            endcase
        end
    end

    // RAM strobes, address and write data follow the winner in the same cycle
    always_comb begin
        mem_readmem  = 1'b0;
        mem_writemem = 1'b0;
        mem_addr     = '0;
        mem_data     = '0;
        if (core_win_s) begin
            mem_readmem  = core_rd;
            mem_writemem = core_wr;
            mem_addr     = core_addr;
            mem_data     = core_wdata;
        end else if (host_win_s) begin
            mem_readmem  = ~host_we;
            mem_writemem = host_we;
            mem_addr     = host_addr;
            mem_data     = host_wdata;
        end else begin
            mem_readmem  = 1'b0;
            mem_writemem = 1'b0;
        end
    end

    assign host_gnt   = host_win_s;
    assign core_stall = core_req_s & ~core_win_s & ~start;

    // priority FSM next state; the limit is checked on the counter's next value so
    // the host wins on the cycle right after its LIMIT-th loss
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CORE_PRIO: begin
                if (starve_next_s == LIMIT_C) begin
                    state_next_s = HOST_FORCE;
                end else begin
                    state_next_s = CORE_PRIO;
                end
            end
            HOST_FORCE: begin
                if (host_win_s) begin
                    state_next_s = CORE_PRIO;
                end else begin
                    state_next_s = HOST_FORCE;
                end
            end
            default: state_next_s = CORE_PRIO;
        endcase
    end

    // record which side issued this cycle's read
    always_comb begin
        rd_owner_next_s = OWN_NONE;
        if (core_win_s && core_rd) begin
            rd_owner_next_s = OWN_CORE;
        end else if (host_win_s && !host_we) begin
            rd_owner_next_s = OWN_HOST;
        end else begin
            rd_owner_next_s = OWN_NONE;
        end
    end

    // FSM and read-owner registers
    always_ff @(posedge clk) begin
        if (start) begin
            state_r    <= CORE_PRIO;
            rd_owner_r <= OWN_NONE;
        end else begin
            state_r    <= state_next_s;
            rd_owner_r <= rd_owner_next_s;
        end
    end

    assign core_rvalid_s = ~start & (rd_owner_r == OWN_CORE);
    assign host_rvalid_s = ~start & (rd_owner_r == OWN_HOST);

    // last delivered read data, shown while the matching rvalid is low
    always_ff @(posedge clk) begin
        if (start) begin
            core_hold_r <= '0;
            host_hold_r <= '0;
        end else begin
            if (core_rvalid_s) begin
                core_hold_r <= mem_q;
            end
            if (host_rvalid_s) begin
                host_hold_r <= mem_q;
            end
        end
    end

    assign core_rvalid = core_rvalid_s;
    assign host_rvalid = host_rvalid_s;
    assign core_rdata  = start ? '0 : (core_rvalid_s ? mem_q : core_hold_r);
    assign host_rdata  = start ? '0 : (host_rvalid_s ? mem_q : host_hold_r);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_core_r;
    logic [15:0] stat_host_r;
    logic [15:0] stat_conf_r;

    // saturating grant and conflict statistics
    always_ff @(posedge clk) begin
        if (start) begin
            stat_core_r <= 16'd0;
            stat_host_r <= 16'd0;
            stat_conf_r <= 16'd0;
        end else begin
            if (core_win_s) begin
                stat_core_r <= sat_inc16(stat_core_r);
            end
            if (host_win_s) begin
                stat_host_r <= sat_inc16(stat_host_r);
            end
            if (core_req_s && host_req) begin
                stat_conf_r <= sat_inc16(stat_conf_r);
            end
        end
    end

    assign stat_core_grants = stat_core_r;
    assign stat_host_grants = stat_host_r;
    assign stat_conflicts   = stat_conf_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural registered-read RAM model;
// the statistics checks are compiled only when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

    logic       clk;
    logic       start;
    logic       core_rd, core_wr;
    logic [7:0] core_addr, core_wdata;
    logic       core_stall, core_rvalid;
    logic [7:0] core_rdata;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdata;
    logic       host_gnt, host_rvalid;
    logic [7:0] host_rdata;
    logic       mem_readmem, mem_writemem;
    logic [7:0] mem_addr, mem_data, mem_q;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_core_grants, stat_host_grants, stat_conflicts;
`endif

    int vec_cnt  = 0;
    int miscmp_cnt = 0;

    logic [7:0] ram [256];

    dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .start        (start),
        .core_rd      (core_rd),
        .core_wr      (core_wr),
        .core_addr    (core_addr),
        .core_wdata   (core_wdata),
        .core_stall   (core_stall),
        .core_rdata   (core_rdata),
        .core_rvalid  (core_rvalid),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rdata   (host_rdata),
        .host_rvalid  (host_rvalid),
        .mem_readmem  (mem_readmem),
        .mem_writemem (mem_writemem),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
`ifdef DMEM_ARB_STATS_EN
        .stat_core_grants (stat_core_grants),
        .stat_host_grants (stat_host_grants),
        .stat_conflicts   (stat_conflicts),
`endif
        .mem_q        (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write in the strobe cycle, registered read data next cycle
    always @(posedge clk) begin
        if (mem_writemem) ram[mem_addr] <= mem_data;
        if (mem_readmem)  mem_q <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = 8'h00;
        mem_q      = 8'h00;
        start      = 1'b1;
        core_rd    = 1'b1;
        core_wr    = 1'b0;
        core_addr  = 8'h10;
        core_wdata = 8'h00;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = 8'h00;
        host_wdata = 8'h00;

        // reset held two cycles with a core read pending
        for (int r = 0; r < 2; r++) begin
            cyc(); settle();
            check_eq("rst_stall",   core_stall,  1'b0);
            check_eq("rst_readmem", mem_readmem, 1'b0);
            check_eq("rst_wrmem",   mem_writemem, 1'b0);
            check_eq("rst_hgnt",    host_gnt,    1'b0);
            check_eq("rst_crvalid", core_rvalid, 1'b0);
            check_eq("rst_crdata",  core_rdata,  8'h00);
            check_eq("rst_hrvalid", host_rvalid, 1'b0);
        end
        start = 1'b0; settle();
        check_eq("rel_readmem", mem_readmem, 1'b1);
        check_eq("rel_addr",    mem_addr,    8'h10);
        check_eq("rel_stall",   core_stall,  1'b0);

        // core store 0xA5 at 0x10, then load it back
        cyc(); core_rd = 1'b0; core_wr = 1'b1; core_wdata = 8'hA5; settle();
        check_eq("st_prev_rvalid", core_rvalid, 1'b1);
        check_eq("st_prev_rdata",  core_rdata,  8'h00);
        check_eq("st_wrmem",  mem_writemem, 1'b1);
        check_eq("st_data",   mem_data,     8'hA5);
        check_eq("st_stall",  core_stall,   1'b0);
        cyc(); core_wr = 1'b0; core_rd = 1'b1; settle();
        check_eq("ld_readmem", mem_readmem, 1'b1);
        check_eq("st_no_rvalid", core_rvalid, 1'b0);
        check_eq("ld_stall",   core_stall,  1'b0);
        cyc(); core_rd = 1'b0; settle();
        check_eq("ld_rvalid", core_rvalid, 1'b1);
        check_eq("ld_rdata",  core_rdata,  8'hA5);
        check_eq("idle_readmem", mem_readmem, 1'b0);
        cyc(); settle();
        check_eq("ld_rvalid_pulse", core_rvalid, 1'b0);
        check_eq("ld_rdata_hold",   core_rdata,  8'hA5);

        // host preload 0x3C at 0x20, then host read
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C; settle();
        check_eq("hw_gnt",   host_gnt,     1'b1);
        check_eq("hw_wrmem", mem_writemem, 1'b1);
        check_eq("hw_addr",  mem_addr,     8'h20);
        cyc(); host_we = 1'b0; settle();
        check_eq("hr_gnt",     host_gnt,    1'b1);
        check_eq("hr_readmem", mem_readmem, 1'b1);
        cyc(); host_req = 1'b0; settle();
        check_eq("hr_rvalid", host_rvalid, 1'b1);
        check_eq("hr_rdata",  host_rdata,  8'h3C);
        check_eq("hr_core_rvalid", core_rvalid, 1'b0);

        // starvation: core reads 0x10 every cycle, host reads 0x20 continuously
        cyc();
        core_rd = 1'b1; core_addr = 8'h10;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        for (int i = 0; i < 10; i++) begin
            settle();
            check_eq($sformatf("starve_gnt%0d", i),   host_gnt,   (i % 5 == 4) ? 1'b1 : 1'b0);
            check_eq($sformatf("starve_stall%0d", i), core_stall, (i % 5 == 4) ? 1'b1 : 1'b0);
            check_eq($sformatf("starve_hrv%0d", i), host_rvalid, (i > 0 && i % 5 == 0) ? 1'b1 : 1'b0);
            check_eq($sformatf("starve_crv%0d", i), core_rvalid, (i > 0 && i % 5 != 0) ? 1'b1 : 1'b0);
            if (i > 0 && i % 5 != 0) check_eq($sformatf("starve_crd%0d", i), core_rdata, 8'hA5);
            cyc();
        end
        core_rd = 1'b0; host_req = 1'b0; settle();
        check_eq("starve_last_hrv", host_rvalid, 1'b1);
        check_eq("starve_last_hrd", host_rdata,  8'h3C);
        check_eq("starve_last_crv", core_rvalid, 1'b0);

        // interleaved reads without cross-routing
        cyc(); host_req = 1'b1; host_we = 1'b1; host_addr = 8'h01; host_wdata = 8'h11; settle();
        check_eq("pre1_gnt", host_gnt, 1'b1);
        cyc(); host_addr = 8'h02; host_wdata = 8'h22; settle();
        check_eq("pre2_gnt", host_gnt, 1'b1);
        cyc(); host_req = 1'b0; core_rd = 1'b1; core_addr = 8'h01; settle();
        check_eq("il_c_addr", mem_addr, 8'h01);
        cyc(); core_rd = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h02; settle();
        check_eq("il_crv",  core_rvalid, 1'b1);
        check_eq("il_crd",  core_rdata,  8'h11);
        check_eq("il_hrv0", host_rvalid, 1'b0);
        check_eq("il_hgnt", host_gnt,    1'b1);
        check_eq("il_h_addr", mem_addr,  8'h02);
        cyc(); host_req = 1'b0; settle();
        check_eq("il_hrv",  host_rvalid, 1'b1);
        check_eq("il_hrd",  host_rdata,  8'h22);
        check_eq("il_crv0", core_rvalid, 1'b0);
        check_eq("il_crd_hold", core_rdata, 8'h11);

        // host read granted, reset the following cycle
        cyc(); host_req = 1'b1; host_we = 1'b0; host_addr = 8'h01; settle();
        check_eq("mr_gnt", host_gnt, 1'b1);
        cyc(); host_req = 1'b0; start = 1'b1; settle();
        check_eq("mr_hrv",     host_rvalid, 1'b0);
        check_eq("mr_hrd",     host_rdata,  8'h00);
        check_eq("mr_readmem", mem_readmem, 1'b0);
        cyc(); settle();
        check_eq("mr_hrv2", host_rvalid, 1'b0);
`ifdef DMEM_ARB_STATS_EN
        check_eq("mr_stat_core", stat_core_grants, 16'd0);
        check_eq("mr_stat_host", stat_host_grants, 16'd0);
        check_eq("mr_stat_conf", stat_conflicts,   16'd0);
`endif

        // after reset: simultaneous requests, core has priority
        start = 1'b0; core_rd = 1'b1; core_addr = 8'h02;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 8'h77; settle();
        check_eq("post_readmem", mem_readmem, 1'b1);
        check_eq("post_addr",    mem_addr,    8'h02);
        check_eq("post_hgnt",    host_gnt,    1'b0);
        check_eq("post_stall",   core_stall,  1'b0);
        cyc(); core_rd = 1'b0; host_req = 1'b0; settle();
        check_eq("post_crv", core_rvalid, 1'b1);
        check_eq("post_crd", core_rdata,  8'h22);
`ifdef DMEM_ARB_STATS_EN
        check_eq("post_stat_core", stat_core_grants, 16'd1);
        check_eq("post_stat_conf", stat_conflicts,   16'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
